// File: rtl/seq_shifter_if.sv
// Start/busy/done handshake and operand/result bus between the execute
// controller and the sequential shifter.
//   start  : request, sampled by the shifter only when idle or done
//   ALUFun : operation select, [1:0] decoded (00 sll, 01 srl, 11 sra, 10 ror)
//   A      : shift amount in the low bits
//   B      : value to shift
//   S      : registered result
//   busy   : operation in flight
//   done   : one-cycle completion pulse
interface seq_shifter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [5:0]       ALUFun;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] S;
  logic             busy;
  logic             done;

  // Execute controller side
  modport master (
    output start, ALUFun, A, B,
    input  S, busy, done
  );

  // Shifter side
  modport slave (
    input  start, ALUFun, A, B,
    output S, busy, done
  );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit. Moves operand B by A[SHAMT_W-1:0] positions,
// at most STEP positions per clock, so a wide datapath can share one narrow
// shifter. Operands are latched on accept; the result appears on S with a
// one-cycle done pulse and is held until the next completion.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : slave side of seq_shifter_if (start/ALUFun/A/B in, S/busy/done out)
module seq_shifter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5,
  parameter int unsigned STEP    = 4
) (
  input  logic        clk,
  input  logic        reset,
  seq_shifter_if.slave bus
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   acc, acc_nxt;
  logic [SHAMT_W-1:0] rem, rem_nxt;
  logic [1:0]         op, op_nxt;
  logic               sign, sign_nxt;
  logic [WIDTH-1:0]   s_q, s_nxt;
  logic               busy_q, busy_nxt;
  logic               done_q, done_nxt;

  logic [SHAMT_W-1:0] k;
  logic [WIDTH-1:0]   fill;
  logic [2*WIDTH-1:0] wide;
  logic [WIDTH-1:0]   step_val;
  logic [SHAMT_W-1:0] shamt_in;

  // Upper operand bits carry no meaning for this unit.
  logic unused_bits;
  assign unused_bits = &{1'b0, bus.ALUFun[5:2], bus.A[WIDTH-1:SHAMT_W]};

  assign shamt_in = bus.A[SHAMT_W-1:0];

  // One step of the datapath: shift acc by k = min(rem, STEP).
  // Right-going ops shift the pair {fill, acc} so the fill source (zeros,
  // latched sign, or acc itself for rotate) enters at the MSB.
  always_comb begin : step_datapath
    if ({1'b0, rem} > (SHAMT_W+1)'(STEP)) begin
      k = SHAMT_W'(STEP);
    end else begin
      k = rem;
    end
    case (op)
      OP_SRA:  fill = {WIDTH{sign}};
      OP_ROR:  fill = acc;
      default: fill = '0;
    endcase
    wide = {fill, acc} >> k;
    if (op == OP_SLL) begin
      step_val = acc << k;
    end else begin
      step_val = wide[WIDTH-1:0];
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk or posedge reset) begin : regs
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      rem    <= '0;
      op     <= '0;
      sign   <= 1'b0;
      s_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      rem    <= rem_nxt;
      op     <= op_nxt;
      sign   <= sign_nxt;
      s_q    <= s_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin : fsm_next
    state_nxt = state;
    acc_nxt   = acc;
    rem_nxt   = rem;
    op_nxt    = op;
    sign_nxt  = sign;
    s_nxt     = s_q;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          acc_nxt  = bus.B;
          rem_nxt  = shamt_in;
          op_nxt   = bus.ALUFun[1:0];
          sign_nxt = bus.B[WIDTH-1];
          if (shamt_in != '0) begin
            state_nxt = RUN;
            busy_nxt  = 1'b1;
          end else begin
            // Zero shift completes without entering RUN.
            state_nxt = DONE;
            s_nxt     = bus.B;
            done_nxt  = 1'b1;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        acc_nxt = step_val;
        rem_nxt = rem - k;
        if (rem == k) begin
          state_nxt = DONE;
          s_nxt     = step_val;
          done_nxt  = 1'b1;
        end else begin
          busy_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.S    = s_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter (WIDTH=32, STEP=4). Expected results
// come from a plain-arithmetic reference of each operation; expected timing
// from ceil(n/STEP).
module tb_seq_shifter;
  localparam int unsigned W    = 32;
  localparam int unsigned SW   = 5;
  localparam int unsigned STEP = 4;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  seq_shifter_if #(.WIDTH(W)) bus ();

  seq_shifter #(.WIDTH(W), .SHAMT_W(SW), .STEP(STEP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_shift(input logic [1:0] op,
                                             input logic [W-1:0] b,
                                             input int n);
    logic signed [W-1:0] sb;
    sb = b;
    case (op)
      2'b00:   return b << n;
      2'b01:   return b >> n;
      2'b11:   return W'(sb >>> n);
      default: return (n == 0) ? b : ((b >> n) | (b << (W - n)));
    endcase
  endfunction

  function automatic int ref_busy(input int n);
    return (n + STEP - 1) / STEP;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle; returns in the first cycle after the start cycle.
  task automatic issue(input logic [5:0] fun, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start  = 1'b1;
    bus.ALUFun = fun;
    bus.A      = a;
    bus.B      = b;
    tick();
    bus.start  = 1'b0;
  endtask

  // Advance until done; lat counts cycles after the start cycle.
  task automatic wait_done(input int lat0, output int lat, output int bcnt, output bit to);
    lat  = lat0;
    bcnt = 0;
    to   = 1'b0;
    while (bus.done !== 1'b1) begin
      if (bus.busy === 1'b1) bcnt++;
      if (lat >= 64) begin
        to = 1'b1;
        break;
      end
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.ALUFun = '0;
    bus.A      = '0;
    bus.B      = '0;
    tick();
    tick();
    tests++;
    if (bus.S !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      $display("FAIL reset_state: S=%h busy=%b done=%b required S=0 busy=0 done=0",
               bus.S, bus.busy, bus.done);
      fails++;
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fixed_ops();
    logic [1:0]   ops [4];
    logic [W-1:0] exp [4];
    int lat, bcnt;
    bit to;
    ops[0] = 2'b00; exp[0] = 32'h8F0F8300;
    ops[1] = 2'b01; exp[1] = 32'h00B38F0F;
    ops[2] = 2'b11; exp[2] = 32'hFFB38F0F;
    ops[3] = 2'b10; exp[3] = 32'h83B38F0F;
    for (int i = 0; i < 4; i++) begin
      issue({4'hA, ops[i]}, 32'd8, 32'hB38F0F83);
      wait_done(1, lat, bcnt, to);
      tests++;
      if (to || bus.S !== exp[i]) begin
        $display("FAIL fixed_op%0d_result: S=%h timeout=%0b required %h", i, bus.S, to, exp[i]);
        fails++;
      end
      tests++;
      if (lat != 3 || bcnt != 2) begin
        $display("FAIL fixed_op%0d_timing: done at %0d busy %0d required 3 and 2", i, lat, bcnt);
        fails++;
      end
      tick();
      tests++;
      if (bus.done !== 1'b0 || bus.S !== exp[i]) begin
        $display("FAIL fixed_op%0d_hold: done=%b S=%h required done=0 S=%h",
                 i, bus.done, bus.S, exp[i]);
        fails++;
      end
    end
  endtask

  task automatic test_zero_shift();
    int lat, bcnt;
    bit to;
    for (int op = 0; op < 4; op++) begin
      issue(6'(op), 32'hFFFFFFE0, 32'h12345678);
      wait_done(1, lat, bcnt, to);
      tests++;
      if (to || lat != 1 || bcnt != 0 || bus.S !== 32'h12345678) begin
        $display("FAIL zero_shift_op%0d: S=%h done at %0d busy %0d required S=12345678 at 1 busy 0",
                 op, bus.S, lat, bcnt);
        fails++;
      end
      tick();
    end
  endtask

  task automatic test_max_shift();
    logic [1:0]   ops [2];
    logic [W-1:0] exp [2];
    int lat, bcnt;
    bit to;
    ops[0] = 2'b11; exp[0] = 32'hFFFFFFFF;
    ops[1] = 2'b01; exp[1] = 32'h00000001;
    for (int i = 0; i < 2; i++) begin
      issue({4'h0, ops[i]}, 32'd31, 32'h80000000);
      wait_done(1, lat, bcnt, to);
      tests++;
      if (to || bus.S !== exp[i] || lat != 9 || bcnt != 8) begin
        $display("FAIL max_shift%0d: S=%h done at %0d busy %0d required S=%h at 9 busy 8",
                 i, bus.S, lat, bcnt, exp[i]);
        fails++;
      end
      tick();
    end
  endtask

  task automatic test_overlap();
    int lat, bcnt, extra;
    bit to;
    issue(6'b000001, 32'd8, 32'hB38F0F83);
    tests++;
    if (bus.busy !== 1'b1) begin
      $display("FAIL overlap_busy: busy=%b required 1", bus.busy);
      fails++;
    end
    bus.start  = 1'b1;
    bus.ALUFun = 6'b000000;
    bus.A      = 32'd4;
    bus.B      = $urandom;
    tick();
    bus.start  = 1'b0;
    bus.A      = $urandom;
    bus.B      = $urandom;
    bus.ALUFun = 6'($urandom);
    wait_done(2, lat, bcnt, to);
    tests++;
    if (to || bus.S !== 32'h00B38F0F || lat != 3) begin
      $display("FAIL overlap_result: S=%h done at %0d required 00B38F0F at 3", bus.S, lat);
      fails++;
    end
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done === 1'b1) extra++;
    end
    tests++;
    if (extra != 0) begin
      $display("FAIL overlap_single_done: extra dones %0d required 0", extra);
      fails++;
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] b1, b2;
    int lat, bcnt;
    bit to;
    b1 = $urandom;
    b2 = $urandom;
    bus.start  = 1'b1;
    bus.ALUFun = 6'b000010;
    bus.A      = 32'd4;
    bus.B      = b1;
    tick();
    // start stays high; these operands only count once the first op is done.
    bus.ALUFun = 6'b000011;
    bus.A      = 32'd8;
    bus.B      = b2;
    wait_done(1, lat, bcnt, to);
    tests++;
    if (to || lat != 2 || bus.S !== ref_shift(2'b10, b1, 4)) begin
      $display("FAIL b2b_first: S=%h done at %0d required %h at 2", bus.S, lat, ref_shift(2'b10, b1, 4));
      fails++;
    end
    tick();
    bus.start = 1'b0;
    tests++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      $display("FAIL b2b_no_bubble: busy=%b done=%b required busy=1 done=0", bus.busy, bus.done);
      fails++;
    end
    wait_done(1, lat, bcnt, to);
    tests++;
    if (to || lat != 3 || bcnt != 2 || bus.S !== ref_shift(2'b11, b2, 8)) begin
      $display("FAIL b2b_second: S=%h done at %0d busy %0d required %h at 3 busy 2",
               bus.S, lat, bcnt, ref_shift(2'b11, b2, 8));
      fails++;
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int lat, bcnt, extra;
    bit to;
    issue(6'b000011, 32'd31, 32'h80000000);
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (bus.S !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      $display("FAIL reset_async: S=%h busy=%b done=%b required 0 0 0", bus.S, bus.busy, bus.done);
      fails++;
    end
    tick();
    @(negedge clk);
    reset = 1'b0;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
    end
    tests++;
    if (extra != 0 || bus.S !== '0) begin
      $display("FAIL reset_abandon: activity %0d S=%h required 0 and 0", extra, bus.S);
      fails++;
    end
    issue(6'b000010, 32'd8, 32'hB38F0F83);
    wait_done(1, lat, bcnt, to);
    tests++;
    if (to || lat != 3 || bus.S !== 32'h83B38F0F) begin
      $display("FAIL reset_recover: S=%h done at %0d required 83B38F0F at 3", bus.S, lat);
      fails++;
    end
    tick();
  endtask

  task automatic test_random();
    logic [1:0]   op;
    logic [W-1:0] a, b, exp;
    int n, lat, bcnt;
    bit to;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
      n  = int'(a[SW-1:0]);
      exp = ref_shift(op, b, n);
      issue({4'($urandom), op}, a, b);
      bus.A = $urandom;
      bus.B = $urandom;
      wait_done(1, lat, bcnt, to);
      tests++;
      if (to || bus.S !== exp || lat != ref_busy(n) + 1 || bcnt != ref_busy(n)) begin
        $display("FAIL random%0d op=%0d n=%0d: S=%h done at %0d busy %0d required %h at %0d busy %0d",
                 i, op, n, bus.S, lat, bcnt, exp, ref_busy(n) + 1, ref_busy(n));
        fails++;
      end
      tick();
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_fixed_ops();
    test_zero_shift();
    test_max_shift();
    test_overlap();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
